// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and default widths for the memory arbiter.
//               Holds the arbiter state enum, the requester-id enum and the
//               default parameter values used by mem_arbiter and its
//               streak counter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MAX_STREAK = 4;
    localparam int DEF_TIMEOUT    = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_e;

endpackage
`default_nettype wire

// File: rtl/arb_streak_ctr.sv
`default_nettype none
// ============================================================================
// Module      : arb_streak_ctr
// Description : Saturating count of data grants made while the fetch port is
//               waiting. o_at_limit tells the arbiter to hand the next grant
//               to the fetch port.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_inc         - count one more data grant (saturates)
//               i_clr         - clear the count (wins over i_inc)
//               o_at_limit    - count has reached MAX_STREAK
// Revision    : 1.0 - initial release
// ============================================================================
module arb_streak_ctr
    import arb_pkg::*;
#(
    parameter int MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam int CNT_W = $clog2(MAX_STREAK + 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_at_limit = (r_cnt == CNT_W'(MAX_STREAK));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_at_limit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one multi-cycle req/ack memory port between the
//               instruction-fetch requester (I, read-only) and the load/store
//               requester (D). One access in flight; D has priority, but after
//               MAX_STREAK data grants with I waiting, I is served next.
// Ports       : clk, rst                         - clock, sync active-high reset
//               i_req/i_addr                     - fetch request
//               i_rvalid/i_rdata/i_err           - fetch response (1 cycle)
//               d_req/d_we/d_addr/d_wdata/d_be   - data request
//               d_rvalid/d_rdata/d_err           - data response (1 cycle)
//               mem_req/we/addr/wdata/be         - memory request, held to ack
//               mem_ack/mem_rdata                - memory completion
//               busy                             - arbiter not idle
// Config      : ARB_TIMEOUT_EN - when defined, a BUSY watchdog of TIMEOUT
//               cycles aborts the access and reports x_err. Otherwise the
//               arbiter waits indefinitely and the err outputs stay 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_STREAK = DEF_MAX_STREAK,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    arb_state_e r_state;
    arb_port_e  w_win;
    logic       w_idle;
    logic       w_grant;
    logic       w_at_limit;
    logic       w_inc;
    logic       w_clr;
    logic       w_tmo;

    assign w_idle  = (r_state == IDLE);
    assign w_grant = w_idle && (i_req || d_req);

    // D wins unless it is absent or has used up its streak.
    always_comb begin
        w_win = PORT_D;
        if (i_req && (!d_req || w_at_limit)) begin
            w_win = PORT_I;
        end
    end

    assign w_inc = w_grant && (w_win == PORT_D) && i_req;
    assign w_clr = (w_grant && (w_win == PORT_I)) || (w_idle && !i_req);

    arb_streak_ctr #(
        .MAX_STREAK (MAX_STREAK)
    ) u_streak (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_inc),
        .i_clr      (w_clr),
        .o_at_limit (w_at_limit)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Fires in the TIMEOUT-th BUSY cycle without an ack; an ack in the same
    // cycle takes precedence in the FSM.
    assign w_tmo = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || w_grant) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == BUSY_I || r_state == BUSY_D) && !mem_ack) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end
`else
    logic w_unused_tmo;

    assign w_tmo        = 1'b0;
    assign w_unused_tmo = (TIMEOUT == 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            i_err     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                        if (w_win == PORT_I) begin
                            r_state   <= BUSY_I;
                            mem_addr  <= i_addr;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                            mem_be    <= '0;
                        end else begin
                            r_state   <= BUSY_D;
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                        end
                    end
                end
                BUSY_I: begin
                    if (mem_ack || w_tmo) begin
                        r_state  <= RESP_I;
                        mem_req  <= 1'b0;
                        i_rvalid <= 1'b1;
                        i_rdata  <= mem_ack ? mem_rdata : '0;
                        i_err    <= !mem_ack;
                    end
                end
                BUSY_D: begin
                    if (mem_ack || w_tmo) begin
                        r_state  <= RESP_D;
                        mem_req  <= 1'b0;
                        d_rvalid <= 1'b1;
                        d_rdata  <= (mem_ack && !mem_we) ? mem_rdata : '0;
                        d_err    <= !mem_ack;
                    end
                end
                RESP_I: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    i_rdata <= '0;
                    i_err   <= 1'b0;
                end
                RESP_D: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    d_rdata <= '0;
                    d_err   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Random requesters and a
//               behavioural memory; a phase/streak reference model predicts
//               every grant and pushes expected responses into per-port
//               queues that a monitor pops when rvalid appears. Directed
//               sequences cover reset, grant order, reset mid-access and the
//               optional timeout (ARB_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MS = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_rvalid, i_err;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_rvalid, d_err;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [BW-1:0] d_be;
    logic          mem_req, mem_we, mem_ack, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [BW-1:0] mem_be;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } resp_t;

    resp_t         qi[$];
    resp_t         qd[$];
    logic [AW-1:0] glog[$];

    // stimulus control
    bit            rand_mode = 1'b0;
    bit            chk_en    = 1'b0;
    bit            fast_ack  = 1'b0;
    bit            f_ireq = 1'b0, f_dreq = 1'b0, f_dwe = 1'b0;
    logic [AW-1:0] f_iaddr = '0, f_daddr = '0;
    logic [DW-1:0] f_dwdata = '0;
    logic [BW-1:0] f_dbe = '0;

    function automatic logic [AW-1:0] rand_addr();
        logic [3:0] w;
        w = 4'($urandom_range(0, 15));
        return {26'd0, w, 2'b00};
    endfunction

    // fetch requester
    initial begin
        i_req  = 1'b0;
        i_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (!rand_mode) begin
                i_req  = f_ireq;
                i_addr = f_iaddr;
            end else if (!i_req || i_rvalid) begin
                if ($urandom_range(0, 2) != 0) begin
                    i_req  = 1'b1;
                    i_addr = rand_addr();
                end else begin
                    i_req = 1'b0;
                end
            end
        end
    end

    // load/store requester
    initial begin
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        forever begin
            @(posedge clk); #1;
            if (!rand_mode) begin
                d_req = f_dreq; d_we = f_dwe; d_addr = f_daddr; d_wdata = f_dwdata; d_be = f_dbe;
            end else if (!d_req || d_rvalid) begin
                if ($urandom_range(0, 4) != 0) begin
                    d_req   = 1'b1;
                    d_we    = 1'($urandom_range(0, 1));
                    d_addr  = rand_addr();
                    d_wdata = $urandom;
                    d_be    = 4'($urandom_range(0, 15));
                end else begin
                    d_req = 1'b0;
                end
            end
        end
    end

    // Reference model: access phases, streak rule and a word memory.
    typedef enum {M_IDLE, M_BUSY, M_RESP} mph_t;
    mph_t mph = M_IDLE;

    initial begin
        int            streak_m;
        int            wait_cnt;
        bit            mport;
        bit            first_busy;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_we;
        logic [BW-1:0] e_be;
        logic [DW-1:0] gm[16];
        logic [3:0]    idx;
        resp_t         r;
        streak_m = 0; wait_cnt = 0; mport = 1'b0; first_busy = 1'b0;
        e_addr = '0; e_wdata = '0; e_we = 1'b0; e_be = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int k = 0; k < 16; k++) gm[k] = $urandom;
        forever begin
            @(negedge clk);
            if (!chk_en || rst) begin
                mph      = M_IDLE;
                streak_m = 0;
                mem_ack  = 1'b0;
            end else begin
                case (mph)
                    M_IDLE: begin
                        mem_ack = 1'b0;
                        chk("idle_mem_req", 64'(mem_req), 64'(0));
                        chk("idle_busy", 64'(busy), 64'(0));
                        if (i_req || d_req) begin
                            mport = (i_req && (!d_req || streak_m == MS)) ? 1'b0 : 1'b1;
                            if (!mport) begin
                                e_addr = i_addr; e_we = 1'b0; e_wdata = '0; e_be = '0;
                                streak_m = 0;
                            end else begin
                                e_addr = d_addr; e_we = d_we; e_wdata = d_wdata; e_be = d_be;
                                streak_m = i_req ? ((streak_m < MS) ? streak_m + 1 : MS) : 0;
                            end
                            mph = M_BUSY; first_busy = 1'b1; wait_cnt = 0;
                        end else begin
                            streak_m = 0;
                        end
                    end
                    M_BUSY: begin
                        chk("busy_mem_req", 64'(mem_req), 64'(1));
                        chk("busy_busy", 64'(busy), 64'(1));
                        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
                        chk("mem_we", 64'(mem_we), 64'(e_we));
                        chk("mem_be", 64'(mem_be), 64'(e_be));
                        if (e_we) chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
                        if (first_busy) begin
                            glog.push_back(mem_addr);
                            first_busy = 1'b0;
                        end
                        if (fast_ack || wait_cnt >= 3 || $urandom_range(0, 1) == 0) begin
                            mem_ack = 1'b1;
                            idx     = e_addr[5:2];
                            r.err   = 1'b0;
                            if (e_we) begin
                                for (int b = 0; b < BW; b++)
                                    if (e_be[b]) gm[idx][8*b +: 8] = e_wdata[8*b +: 8];
                                mem_rdata = $urandom;
                                r.data    = '0;
                            end else begin
                                mem_rdata = gm[idx];
                                r.data    = gm[idx];
                            end
                            if (mport) qd.push_back(r);
                            else       qi.push_back(r);
                            mph = M_RESP;
                        end else begin
                            mem_ack   = 1'b0;
                            mem_rdata = $urandom;
                            wait_cnt++;
                        end
                    end
                    default: begin
                        mem_ack = 1'b0;
                        chk("resp_mem_req", 64'(mem_req), 64'(0));
                        chk("resp_busy", 64'(busy), 64'(1));
                        mph = M_IDLE;
                    end
                endcase
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a port presents rvalid.
    initial begin
        int    wi;
        int    wd;
        resp_t r;
        wi = 0; wd = 0;
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                if (i_rvalid) begin
                    if (qi.size() == 0) begin
                        chk("i_rvalid_unexpected", 64'(1), 64'(0));
                    end else begin
                        r = qi.pop_front();
                        chk("i_rdata", 64'(i_rdata), 64'(r.data));
                        chk("i_err", 64'(i_err), 64'(r.err));
                    end
                    wi = 0;
                end else if (qi.size() > 0) begin
                    wi++;
                    if (wi > 1) begin
                        chk("i_rvalid_missing", 64'(0), 64'(1));
                        qi.delete();
                        wi = 0;
                    end
                end
                if (d_rvalid) begin
                    if (qd.size() == 0) begin
                        chk("d_rvalid_unexpected", 64'(1), 64'(0));
                    end else begin
                        r = qd.pop_front();
                        chk("d_rdata", 64'(d_rdata), 64'(r.data));
                        chk("d_err", 64'(d_err), 64'(r.err));
                    end
                    wd = 0;
                end else if (qd.size() > 0) begin
                    wd++;
                    if (wd > 1) begin
                        chk("d_rvalid_missing", 64'(0), 64'(1));
                        qd.delete();
                        wd = 0;
                    end
                end
            end
        end
    end

    task automatic quiet();
        int n;
        n = 0;
        while (!(mph == M_IDLE && !i_req && !d_req && qi.size() == 0 && qd.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("quiet_timeout", 64'(0), 64'(1));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_mem_be", 64'(mem_be), 64'(0));
        chk("rst_i_rvalid", 64'(i_rvalid), 64'(0));
        chk("rst_i_rdata", 64'(i_rdata), 64'(0));
        chk("rst_i_err", 64'(i_err), 64'(0));
        chk("rst_d_rvalid", 64'(d_rvalid), 64'(0));
        chk("rst_d_rdata", 64'(d_rdata), 64'(0));
        chk("rst_d_err", 64'(d_err), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en    = 1'b1;
        rand_mode = 1'b1;

        // randomized traffic against the reference model
        repeat (3000) @(posedge clk);
        rand_mode = 1'b0;
        quiet();

        // both held, single-cycle ack: D,D,D,D,I repeating
        fast_ack = 1'b1;
        glog.delete();
        f_iaddr = 32'h40; f_daddr = 32'h80; f_dwe = 1'b0;
        f_ireq = 1'b1; f_dreq = 1'b1;
        n = 0;
        while (glog.size() < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        f_ireq = 1'b0; f_dreq = 1'b0;
        if (glog.size() < 10) begin
            chk("order_count", 64'(glog.size()), 64'(10));
        end else begin
            for (int k = 0; k < 10; k++)
                chk($sformatf("order_%0d", k), 64'(glog[k]), 64'((k % 5 == 4) ? 32'h40 : 32'h80));
        end
        quiet();
        fast_ack = 1'b0;

        // reset while a data access is waiting for its ack
        chk_en = 1'b0;
        f_daddr = 32'h100; f_dwe = 1'b0; f_dreq = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_req) seen = 1'b1;
        end
        chk("rst_mid_granted", 64'(seen), 64'(1));
        rst = 1'b1;
        f_dreq = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_d_rvalid", 64'(d_rvalid), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        f_iaddr = 32'h20; f_ireq = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (d_rvalid) chk("rst_mid_late_d_rvalid", 64'(1), 64'(0));
            if (i_rvalid) seen = 1'b1;
        end
        chk("post_rst_i_served", 64'(seen), 64'(1));
        f_ireq = 1'b0;
        quiet();

`ifdef ARB_TIMEOUT_EN
        // memory never acks: watchdog aborts after TIMEOUT busy cycles
        chk_en = 1'b0;
        f_daddr = 32'h104; f_dwe = 1'b0; f_dreq = 1'b1;
        n = 0; seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (mem_req) n++;
            if (d_rvalid) begin
                seen = 1'b1;
                chk("tmo_d_err", 64'(d_err), 64'(1));
                chk("tmo_d_rdata", 64'(d_rdata), 64'(0));
            end
        end
        chk("tmo_rvalid_seen", 64'(seen), 64'(1));
        chk("tmo_req_cycles", 64'(n), 64'(TO));
        f_dreq = 1'b0;
        repeat (3) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one backing memory port between the instruction-fetch requester (I, read-only) and the load/store requester (D, read/write).
- Sits between the core (PC/InstrMem fetch path, datapath load/store path) and a unified memory with a multi-cycle req/ack interface.
- One access is in flight at a time.
- D has priority over I; a streak limit prevents I starvation.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- MAX_STREAK, 4, consecutive D grants allowed while I is waiting
- TIMEOUT, 64, watchdog cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  fetch request; held until i_rvalid
- i_addr  in  ADDR_W  fetch address
- i_rvalid  out  1  one-cycle fetch completion
- i_rdata  out  DATA_W  fetched word, valid with i_rvalid
- i_err  out  1  fetch aborted, valid with i_rvalid
- d_req  in  1  data request; held until d_rvalid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_rvalid  out  1  one-cycle data completion (loads and stores)
- d_rdata  out  DATA_W  load data; 0 for stores
- d_err  out  1  data access aborted, valid with d_rvalid
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_ack  in  1  one-cycle completion; meaningful only while mem_req=1
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- busy  out  1  FSM not in IDLE

Behaviour:
- All outputs are registered. On reset every output is 0, FSM=IDLE, streak=0.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - No request pending: stay in IDLE.
  - Only i_req: go to BUSY_I. Only d_req: go to BUSY_D.
  - Both pending: go to BUSY_I if streak==MAX_STREAK, else BUSY_D.
  - On the transition edge, latch the winner's addr/we/wdata/be onto mem_*. mem_req=1 from the first BUSY cycle. I accesses force mem_we=0 and mem_be=0.
- BUSY_x: hold mem_* stable. When mem_ack=1, capture mem_rdata (or 0 for a store) and go to RESP_x; mem_req=0 from that edge.
- RESP_x: x_rvalid=1 and x_rdata valid for exactly one cycle, then return to IDLE. Requests are not sampled in RESP.
- Requesters either drop or change their request by the following IDLE cycle.
- Minimum access, first BUSY cycle acked: request sampled in IDLE at cycle N, rvalid at N+2, next grant sampled at N+3.
- Streak counter:
  - Increments (saturating at MAX_STREAK) on a D grant while i_req=1.
  - Clears on any I grant, and in any IDLE cycle with i_req=0.
  - With i_req held continuously, at most MAX_STREAK D accesses complete before an I access.
- Inputs are ignored while in BUSY or RESP. A requester changing its payload mid-access has no effect on mem_*.
- Reset mid-access returns to IDLE on the next edge with mem_req=0 and no rvalid. The memory tolerates an abandoned request.
- i_err and d_err are 0 unless ARB_TIMEOUT_EN is defined.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: a cycle counter clears on BUSY entry and increments each BUSY cycle without mem_ack. On reaching TIMEOUT, go to RESP_x with x_err=1 and x_rdata=0; mem_req drops on that edge. An ack in the same cycle as the timeout wins (normal completion).
- Undefined: no counter; BUSY waits indefinitely; err ports are tied 0. Port list is identical in both builds.

Decomposition:
- Package arb_pkg: state enum (IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D), port-id enum (PORT_I, PORT_D), default width constants.
- One sub-module, arb_streak_ctr: saturating streak counter with inc/clr inputs and an at_limit output.
- FSM, payload mux and response registers stay in mem_arbiter.

Test Plan:
- Single load: d_req, d_addr=0x100, mem_ack 2 cycles after mem_req with mem_rdata=0xDEADBEEF -> one-cycle d_rvalid with d_rdata=0xDEADBEEF; i_rvalid stays 0.
- Store: d_we=1, d_be=0b0011, d_wdata=0x1234 -> mem_we=1, mem_be=0b0011, mem_wdata=0x1234 held until ack; d_rvalid=1 with d_rdata=0.
- Simultaneous requests, MAX_STREAK=4, both held, 1-cycle ack -> memory grant order D,D,D,D,I,D,D,D,D,I.
- I only, ack in the first BUSY cycle -> i_rvalid every 3 cycles; mem_we and mem_be always 0.
- rst asserted during BUSY_D -> next edge: mem_req=0, busy=0, no d_rvalid; a new i_req afterwards is served normally.
- ARB_TIMEOUT_EN, TIMEOUT=8, mem_ack never asserted -> mem_req high for exactly 8 cycles; then d_rvalid=1, d_err=1, d_rdata=0.
